// File: rtl/memc_ctrl_pkg.sv
// Shared constants for the memc sequencer: array geometry plus the flush end marker.
`ifndef MEM_SYS_CONSTANTS_DEFS
`define MEM_SYS_CONSTANTS_DEFS
`define L1_NUM_SETS 256
`define MEMC_ADDR_W 8
`endif

package memc_ctrl_pkg;
    localparam int ADDR_W   = `MEMC_ADDR_W;
    localparam int NUM_SETS = `L1_NUM_SETS;
    localparam logic [ADDR_W-1:0] LAST_SET = ADDR_W'(NUM_SETS - 1);
endpackage

// File: rtl/memc_ctrl_if.sv
// Requester, response, flush and array-side signals between the requesters, memc_ctrl and memc.
interface memc_ctrl_if
    import memc_ctrl_pkg::*;
#(
    parameter int Size = 16
);
    logic              req0_valid, req0_write, req0_grant;
    logic [ADDR_W-1:0] req0_addr;
    logic [Size-1:0]   req0_wdata;
    logic              req1_valid, req1_write, req1_grant;
    logic [ADDR_W-1:0] req1_addr;
    logic [Size-1:0]   req1_wdata;
    logic              rsp_valid, rsp_id;
    logic [Size-1:0]   rsp_data;
    logic              flush_req, flush_busy, flush_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [Size-1:0]   mem_wdata, mem_rdata;
    logic              mem_write;

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        input  flush_req, mem_rdata,
        output req0_grant, req1_grant, rsp_valid, rsp_id, rsp_data,
        output flush_busy, flush_done, mem_addr, mem_wdata, mem_write
    );

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        output flush_req, mem_rdata,
        input  req0_grant, req1_grant, rsp_valid, rsp_id, rsp_data,
        input  flush_busy, flush_done, mem_addr, mem_wdata, mem_write
    );
endinterface

// File: rtl/memc.sv
// Single-port cache array: combinational read, write at the edge, cleared on reset.
module memc
    import memc_ctrl_pkg::*;
#(
    parameter int Size = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              createdump,
    input  logic [4:0]        file_id,
    input  logic [ADDR_W-1:0] addr,
    input  logic [Size-1:0]   data_in,
    input  logic              write,
    output logic [Size-1:0]   data_out
);
    logic [Size-1:0] mem [NUM_SETS];
    logic            unused_dump;

    // Dump support is not modelled; the pins exist only for port compatibility.
    assign unused_dump = createdump ^ (^file_id);
    assign data_out    = write ? '0 : mem[addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SETS; i++) mem[i] <= '0;
        end else if (write) begin
            mem[addr] <= data_in;
        end
    end
endmodule

// File: rtl/memc_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the pointer flips to the loser after every grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);
    logic rr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (&req) gnt = rr ? 2'b10 : 2'b01;
            else      gnt = req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)       rr <= 1'b0;
        else if (|gnt) rr <= gnt[0];
    end
endmodule

// File: rtl/memc_ctrl.sv
// Arbitrates two requesters onto one memc array and runs a flush walk that zeroes every set.
module memc_ctrl
    import memc_ctrl_pkg::*;
#(
    parameter int Size = 16
) (
    input  logic        clk,
    input  logic        rst,
    memc_ctrl_if.slave  bus
);
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_FLUSH = 1'b1;
    typedef enum logic {IDLE = ST_IDLE, FLUSH = ST_FLUSH} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [1:0]        gnt;
    logic              arb_en, rd_gnt, rd_id;
    logic              rsp_valid_q, rsp_id_q, busy_q, done_q;
    logic [Size-1:0]   rsp_data_q;

    // A flush request in IDLE pre-empts any pending access that cycle.
    assign arb_en = !rst && (state == IDLE) && !bus.flush_req;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({bus.req1_valid, bus.req0_valid}),
        .en  (arb_en),
        .gnt (gnt)
    );

    assign bus.req0_grant = gnt[0];
    assign bus.req1_grant = gnt[1];

    always_comb begin
        state_nxt     = state;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_write = 1'b0;
        rd_gnt        = 1'b0;
        rd_id         = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (bus.flush_req) begin
                        state_nxt = FLUSH;
                    end else if (gnt[0]) begin
                        bus.mem_addr  = bus.req0_addr;
                        bus.mem_write = bus.req0_write;
                        bus.mem_wdata = bus.req0_write ? bus.req0_wdata : '0;
                        rd_gnt        = !bus.req0_write;
                    end else if (gnt[1]) begin
                        bus.mem_addr  = bus.req1_addr;
                        bus.mem_write = bus.req1_write;
                        bus.mem_wdata = bus.req1_write ? bus.req1_wdata : '0;
                        rd_gnt        = !bus.req1_write;
                        rd_id         = 1'b1;
                    end
                end
                FLUSH: begin
                    bus.mem_write = 1'b1;
                    bus.mem_addr  = cnt;
                    if (cnt == LAST_SET) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            // The 8-bit wrap at the last set lands exactly on the return to IDLE.
            cnt         <= (state == FLUSH) ? cnt + 1'b1 : '0;
            rsp_valid_q <= rd_gnt;
            if (rd_gnt) begin
                rsp_id_q   <= rd_id;
                rsp_data_q <= bus.mem_rdata;
            end
            busy_q      <= (state_nxt == FLUSH);
            done_q      <= (state == FLUSH) && (state_nxt == IDLE);
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.flush_busy = busy_q;
    assign bus.flush_done = done_q;
endmodule

// File: tb/tb_memc_ctrl.sv
// Directed bench for memc_ctrl + memc with a read-response scoreboard.
module tb_memc_ctrl;
    import memc_ctrl_pkg::*;

    typedef struct {
        logic        id;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          total = 0;
    int          bad = 0;
    int          cyc_n = 0;
    exp_t        sb[$];
    logic [15:0] model [256];

    memc_ctrl_if #(.Size(16)) ifc ();

    memc_ctrl #(.Size(16)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    memc #(.Size(16)) u_mem (
        .clk(clk), .rst(rst), .createdump(1'b0), .file_id(5'd0),
        .addr(ifc.mem_addr), .data_in(ifc.mem_wdata), .write(ifc.mem_write),
        .data_out(ifc.mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Response monitor: every rsp_valid must match the oldest expected read, one cycle after its grant.
    always @(negedge clk) begin
        if (ifc.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(ifc.rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_cycle", 32'(cyc_n), 32'(e.cyc + 1));
                chk("rsp_id", 32'(ifc.rsp_id), 32'(e.id));
                chk("rsp_data", 32'(ifc.rsp_data), 32'(e.data));
            end
        end
    end

    task automatic set_req(input logic v0, input logic w0, input logic [7:0] a0, input logic [15:0] d0,
                           input logic v1, input logic w1, input logic [7:0] a1, input logic [15:0] d1);
        ifc.req0_valid = v0; ifc.req0_write = w0; ifc.req0_addr = a0; ifc.req0_wdata = d0;
        ifc.req1_valid = v1; ifc.req1_write = w1; ifc.req1_addr = a1; ifc.req1_wdata = d1;
    endtask

    task automatic apply(input logic id);
        logic       w;
        logic [7:0] a;
        logic [15:0] d;
        w = id ? ifc.req1_write : ifc.req0_write;
        a = id ? ifc.req1_addr  : ifc.req0_addr;
        d = id ? ifc.req1_wdata : ifc.req0_wdata;
        if (w) model[a] = d;
        else   sb.push_back('{id: id, data: model[a], cyc: cyc_n});
    endtask

    // Called at the negedge: check grants against the expectation and advance the model.
    task automatic judge(input logic eg0, input logic eg1);
        chk("req0_grant", 32'(ifc.req0_grant), 32'(eg0));
        chk("req1_grant", 32'(ifc.req1_grant), 32'(eg1));
        if (eg0)      apply(1'b0);
        else if (eg1) apply(1'b1);
    endtask

    task automatic cyc(input logic eg0, input logic eg1);
        @(negedge clk);
        judge(eg0, eg1);
        @(posedge clk); #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model[i] = 16'h0;
    endtask

    initial begin
        logic seen_done;
        clear_model();
        ifc.flush_req = 1'b0;
        set_req(1'b1, 1'b0, 8'h01, 16'h0, 1'b1, 1'b0, 8'h02, 16'h0);

        // Reset: registered outputs 0, combinational outputs held at 0.
        repeat (2) begin
            @(negedge clk);
            chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
            chk("rst_rsp_data", 32'(ifc.rsp_data), 32'd0);
            chk("rst_busy", 32'(ifc.flush_busy), 32'd0);
            chk("rst_done", 32'(ifc.flush_done), 32'd0);
            chk("rst_grant0", 32'(ifc.req0_grant), 32'd0);
            chk("rst_mem_write", 32'(ifc.mem_write), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Contention from reset alternates starting with requester 0.
        for (int i = 0; i < 6; i++) cyc(i % 2 == 0, i % 2 == 1);
        set_req(1'b1, 1'b0, 8'h01, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
        repeat (3) cyc(1'b1, 1'b0);

        // Single requester write then read back.
        set_req(1'b1, 1'b1, 8'h12, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0);
        cyc(1'b1, 1'b0);
        set_req(1'b1, 1'b0, 8'h12, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
        cyc(1'b1, 1'b0);

        // Write from requester 1, read from requester 0 the next cycle.
        set_req(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b1, 8'h40, 16'h0055);
        cyc(1'b0, 1'b1);
        set_req(1'b1, 1'b0, 8'h40, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
        cyc(1'b1, 1'b0);

        // Fill sets 0, 128, 255 then flush with a competing request.
        set_req(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b1, 8'h00, 16'h1111);
        cyc(1'b0, 1'b1);
        set_req(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b1, 8'h80, 16'h2222);
        cyc(1'b0, 1'b1);
        set_req(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b1, 8'hFF, 16'h3333);
        cyc(1'b0, 1'b1);
        set_req(1'b1, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
        ifc.flush_req = 1'b1;
        cyc(1'b0, 1'b0);
        ifc.flush_req = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            chk("fl_busy", 32'(ifc.flush_busy), 32'd1);
            chk("fl_done", 32'(ifc.flush_done), 32'd0);
            chk("fl_grant0", 32'(ifc.req0_grant), 32'd0);
            chk("fl_mem_write", 32'(ifc.mem_write), 32'd1);
            chk("fl_mem_addr", 32'(ifc.mem_addr), 32'(i));
            chk("fl_mem_wdata", 32'(ifc.mem_wdata), 32'd0);
            @(posedge clk); #1;
        end
        clear_model();
        @(negedge clk);
        chk("fl_end_busy", 32'(ifc.flush_busy), 32'd0);
        chk("fl_end_done", 32'(ifc.flush_done), 32'd1);
        judge(1'b1, 1'b0);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 8'h80, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
        cyc(1'b1, 1'b0);
        set_req(1'b1, 1'b0, 8'hFF, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
        @(negedge clk);
        chk("done_one_cycle", 32'(ifc.flush_done), 32'd0);
        judge(1'b1, 1'b0);
        @(posedge clk); #1;

        // Reset in the middle of a flush.
        set_req(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b1, 8'h07, 16'h1234);
        cyc(1'b0, 1'b1);
        set_req(1'b1, 1'b0, 8'h07, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
        cyc(1'b1, 1'b0);
        set_req(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
        ifc.flush_req = 1'b1;
        cyc(1'b0, 1'b0);
        ifc.flush_req = 1'b0;
        repeat (99) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_mem_write", 32'(ifc.mem_write), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        chk("abort_busy", 32'(ifc.flush_busy), 32'd0);
        seen_done = 1'b0;
        repeat (300) begin
            @(negedge clk);
            seen_done = seen_done | ifc.flush_done;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 8'h07, 16'h0);
        cyc(1'b0, 1'b1);
        // Pointer was restored to requester 0 by reset, then flipped by the grant above.
        set_req(1'b1, 1'b0, 8'h12, 16'h0, 1'b1, 1'b0, 8'h40, 16'h0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        set_req(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
        repeat (3) cyc(1'b0, 1'b0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/memc_ctrl.md
# memc_ctrl

Single-port sequencer and arbiter in front of one `memc` cache array (data, tag or dirty array of an L1). Shares the array between two requesters (req0 = core pipeline, req1 = fill/writeback engine) with round-robin priority. Provides a hardware flush walk that zeroes all 256 sets. Sits between the cache controller FSM and the `memc` instance and drives its `addr`/`data_in`/`write` pins; `createdump`/`file_id` remain wired directly to `memc`.

## Interface
Parameters:
- `Size`, default 16: data width; must match the attached `memc` `Size`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has an access pending; held until granted.
- `req0_write` in 1: 1 = write, 0 = read.
- `req0_addr` in 8: set index.
- `req0_wdata` in Size: write data.
- `req0_grant` out 1: access accepted this cycle; combinational.
- `req1_valid`, `req1_write`, `req1_addr`, `req1_wdata`, `req1_grant`: same as requester 0.
- `rsp_valid` out 1: read data valid; one-cycle pulse.
- `rsp_id` out 1: requester that issued the read.
- `rsp_data` out Size: registered read data.
- `flush_req` in 1: start a flush walk; level-sampled in IDLE.
- `flush_busy` out 1: high for the whole FLUSH state.
- `flush_done` out 1: one-cycle pulse after the last set is cleared.
- `mem_addr` out 8: to `memc.addr`.
- `mem_wdata` out Size: to `memc.data_in`.
- `mem_write` out 1: to `memc.write`.
- `mem_rdata` in Size: from `memc.data_out`, combinational read.

## Operation
- FSM states: IDLE, FLUSH.
- IDLE with `flush_req`=1:
  - no grants that cycle.
  - next state FLUSH, flush counter = 0.
  - `flush_req` wins over any pending requests.
- IDLE with `flush_req`=0, arbitration:
  - Only one valid requester: it is granted.
  - Both valid: the requester selected by round-robin pointer `rr` is granted.
  - After any grant, `rr` points to the other requester.
  - `rr` does not change when nothing is granted.
- Granted write: `mem_write`=1, `mem_addr`/`mem_wdata` taken from the winner; array updated at the next edge.
- Granted read: `mem_write`=0, `mem_addr` taken from the winner; `mem_rdata` registered at the edge into `rsp_data`.
- No grant: `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
- FLUSH:
  - each cycle `mem_write`=1, `mem_addr`=counter, `mem_wdata`=0; counter increments.
  - On counter = 255 the write is issued, then next state IDLE.
  - No grants in FLUSH; `flush_req` is ignored.
- Counter is 8 bits. The 255→0 wrap coincides with the exit from FLUSH; no extra bit.
- At most one array access per cycle, so there is no read/write collision. `memc` outputs 0 while `write`=1, which is harmless because reads are never issued in a write cycle.
- Reset in any state:
  - next state IDLE, counter 0, `rr`=0 (requester 0 preferred first).
  - `rsp_valid`=0, `flush_busy`=0.
  - no `flush_done` pulse for an aborted flush.
  - The array contents are cleared by `memc` itself on reset.

## Timing
- Grants are combinational from `*_valid`, state and `rr`. A transfer occurs on `valid & grant` at the clock edge.
- Read latency is 1: a grant in cycle N gives `rsp_valid`=1, `rsp_id`, and `rsp_data` in cycle N+1. Back-to-back reads give back-to-back responses.
- Write: `memc` contents change at the edge ending the grant cycle. A read granted in N+1 returns the new data.
- Flush with `flush_req` high in cycle T:
  - FLUSH spans cycles T+1..T+256 and clears addresses 0..255.
  - `flush_busy` is high for cycles T+1..T+256.
  - `flush_done` pulses in T+257, the first IDLE cycle; grants are possible in T+257.
- Reset values: all registered outputs 0 (`rsp_valid`, `rsp_id`, `rsp_data`, `flush_busy`, `flush_done`). Combinational outputs are 0 while `rst`=1.

## Structure
- The array depth (`L1_NUM_SETS`) and the address width (8) come from the shared `mem_sys_constants` defines. Add a `MEMC_ADDR_W` define there; no local magic numbers.
- FSM state encodings are local `localparam`s.
- One natural sub-module, `rr_arb2`: a 2-way round-robin arbiter with a registered pointer. Inputs: `clk`, `rst`, `req[1:0]`, `en`. Output: `gnt[1:0]`. `memc_ctrl` holds `en` low during FLUSH and flush-start cycles.
- Bench instantiates `memc_ctrl` + `memc` together.

## Test plan
- Single requester: req0 write addr 0x12 data 0xBEEF, then req0 read 0x12 → grant each cycle; `rsp_valid` one cycle after the read grant with `rsp_id`=0, `rsp_data`=0xBEEF.
- Contention: both valid continuously for 6 cycles after reset → grants alternate 0,1,0,1,0,1. Then drop req1 → req0 granted every cycle.
- Flush: fill sets 0, 128, 255 with nonzero data, pulse `flush_req` at T → `flush_busy` for 256 cycles, `flush_done` at T+257; reads of 0/128/255 return 0.
- Flush vs request: `flush_req` and req0_valid high in the same cycle → no grant during T..T+256; req0 granted at T+257.
- Reset mid-flush: assert `rst` at T+100 → `flush_busy`=0 next cycle, no `flush_done`; after release, req1 read of any set returns 0.
- Read after write from different requesters: req1 writes 0x55 at 0x40 in N, req0 reads 0x40 in N+1 → `rsp_data`=0x55, `rsp_id`=0 in N+2.
